// File: rtl/board_gen_ctrl.sv
// board_gen_ctrl
// ----------------------------------------------------------------------------
// Board generator top level. It runs entirely on sys_clk and has no derived
// clock.
//
// The raw "random" and "generate" buttons are debounced into single-cycle
// flags. The random flag toggles the random-mode LED. The generate flag builds
// a BOARD_W-bit board that contains min(num, BOARD_W) set cells. The cells are
// placed in one of two ways:
//   - deterministic: consecutive cells starting at a game_s-derived offset,
//     wrapping modulo BOARD_W.
//   - random: a sweeping pointer places a cell only when that cell is empty
//     and the free-running LFSR bit 0 is 1.
//
// Ports
//   sys_clk     in   system clock
//   rst_sw      in   synchronous active-low reset
//   rd_bt       in   raw random-mode toggle button
//   gen_bt      in   raw generate-board button
//   game_s      in   game select, sets the deterministic start offset
//   num         in   requested number of set cells
//   rd_led      out  current random-mode state
//   gs_led      out  combinational mirror of game_s
//   num_led     out  combinational mirror of num
//   busy        out  high while a board is being built (LOAD/FILL)
//   board_valid out  high while board holds a completed board
//   board       out  generated board, bit i = cell i
//
// Status semantics: busy and board_valid are never high together. A
// generate request is accepted only in IDLE. Acceptance drops board_valid
// and clears board during LOAD. board_valid rises in the DONE cycle and
// stays high, with board stable, until the next accepted request or reset.
// Requests seen while busy are dropped, not queued.
// ----------------------------------------------------------------------------
module board_gen_ctrl #(
    parameter int          BOARD_W    = 12,
    parameter int          NUM_W      = 5,
    parameter int          MODE_W     = 2,
    parameter int          DEB_CYCLES = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              sys_clk,
    input  logic              rst_sw,
    input  logic              rd_bt,
    input  logic              gen_bt,
    input  logic [MODE_W-1:0] game_s,
    input  logic [NUM_W-1:0]  num,
    output logic              rd_led,
    output logic [MODE_W-1:0] gs_led,
    output logic [NUM_W-1:0]  num_led,
    output logic              busy,
    output logic              board_valid,
    output logic [BOARD_W-1:0] board
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int PTR_W = $clog2(BOARD_W);
    localparam int CNT_W = $clog2(BOARD_W + 1);

    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_PRE  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [DEB_W-1:0] DEB_ZERO = '0;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BOARD_W - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = '0;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BOARD_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // Step between game offsets: the board is split into quarters.
    localparam int unsigned GAME_STEP = BOARD_W / 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [DEB_W-1:0]   gen_cnt;
    logic [DEB_W-1:0]   rd_cnt;
    logic               gen_flag;
    logic               rd_flag;
    logic               rd_mode;
    logic [15:0]        lfsr;

    state_t             state_q,  state_d;
    logic [BOARD_W-1:0] board_q,  board_d;
    logic               valid_q,  valid_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   placed_q, placed_d;
    logic [PTR_W-1:0]   ptr_q,    ptr_d;
    logic               mode_q,   mode_d;

    logic [CNT_W-1:0]   target_calc;
    logic [PTR_W-1:0]   det_ptr;
    logic               place;

    // ------------------------------------------------------------------
    // Mirrors
    // ------------------------------------------------------------------
    assign gs_led  = game_s;
    assign num_led = num;

    // ------------------------------------------------------------------
    // Debouncers. The counter saturates at DEB_CYCLES while the button
    // is held, so a long press produces one flag. The flag is registered
    // together with the counter, so it is high exactly in the cycle where
    // the counter first shows DEB_CYCLES.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!rst_sw) begin
            gen_cnt  <= DEB_ZERO;
            gen_flag <= 1'b0;
        end else if (gen_bt) begin
            if (gen_cnt != DEB_MAX) begin
                gen_cnt <= gen_cnt + DEB_ONE;
            end
            gen_flag <= (gen_cnt == DEB_PRE);
        end else begin
            gen_cnt  <= DEB_ZERO;
            gen_flag <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_sw) begin
            rd_cnt  <= DEB_ZERO;
            rd_flag <= 1'b0;
        end else if (rd_bt) begin
            if (rd_cnt != DEB_MAX) begin
                rd_cnt <= rd_cnt + DEB_ONE;
            end
            rd_flag <= (rd_cnt == DEB_PRE);
        end else begin
            rd_cnt  <= DEB_ZERO;
            rd_flag <= 1'b0;
        end
    end

    // The random-mode toggle is honoured in every FSM state. A running
    // generation keeps its own latched copy of the mode.
    always_ff @(posedge sys_clk) begin
        if (!rst_sw) begin
            rd_mode <= 1'b0;
        end else if (rd_flag) begin
            rd_mode <= ~rd_mode;
        end
    end

    assign rd_led = rd_mode;

    // ------------------------------------------------------------------
    // 16-bit Fibonacci LFSR, taps 16,14,13,11, in right-shift form. It
    // free-runs every cycle out of reset, so the random board depends on
    // when the request arrives.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!rst_sw) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    // ------------------------------------------------------------------
    // Request decode: clamp the count to the board size and derive the
    // deterministic start cell from game_s.
    // ------------------------------------------------------------------
    assign target_calc = (32'(num) >= 32'(BOARD_W)) ? CNT_FULL : CNT_W'(num);
    assign det_ptr     = PTR_W'((32'(game_s) * 32'(GAME_STEP)) % 32'(BOARD_W));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!rst_sw) begin
            state_q  <= IDLE;
            board_q  <= '0;
            valid_q  <= 1'b0;
            target_q <= CNT_ZERO;
            placed_q <= CNT_ZERO;
            ptr_q    <= PTR_ZERO;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            valid_q  <= valid_d;
            target_q <= target_d;
            placed_q <= placed_d;
            ptr_q    <= ptr_d;
            mode_q   <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        valid_d  = valid_q;
        target_d = target_q;
        placed_d = placed_q;
        ptr_d    = ptr_q;
        mode_d   = mode_q;
        place    = 1'b0;

        case (state_q)
            IDLE: begin
                if (gen_flag) begin
                    // Latch on the accepting edge. rd_mode still holds the
                    // old mode here, even if rd_flag toggles it in the
                    // same cycle.
                    state_d  = LOAD;
                    board_d  = '0;
                    valid_d  = 1'b0;
                    target_d = target_calc;
                    mode_d   = rd_mode;
                    ptr_d    = rd_mode ? PTR_ZERO : det_ptr;
                    placed_d = CNT_ZERO;
                end
            end

            LOAD: begin
                if (target_q == CNT_ZERO) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end else begin
                    state_d = FILL;
                end
            end

            FILL: begin
                place = !mode_q || (!board_q[ptr_q] && lfsr[0]);
                if (place) begin
                    board_d[ptr_q] = 1'b1;
                    placed_d       = placed_q + CNT_ONE;
                end
                ptr_d = (ptr_q == PTR_LAST) ? PTR_ZERO : ptr_q + PTR_ONE;
                if (place && (placed_q + CNT_ONE == target_q)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q == LOAD) || (state_q == FILL);
    assign board_valid = valid_q;
    assign board       = board_q;

endmodule

// File: doc/board_gen_ctrl.md
Name: board_gen_ctrl

Overview:
- Parametrised successor to the board-generator top-level.
- Debounces the "random" and "generate" buttons into single-cycle flags and keeps the random-mode toggle.
- On request, builds a BOARD_W-bit game board containing min(num, BOARD_W) set cells, either deterministically (game_s-seeded offset) or pseudo-randomly (LFSR).
- Runs on sys_clk directly, with no derived clock, and reports busy/valid to the display/game logic.

Parameters:
- BOARD_W, 12, board width in cells (>=2).
- NUM_W, 5, width of num input.
- MODE_W, 2, width of game_s input.
- DEB_CYCLES, 16, consecutive stable-high cycles needed to accept a button press (>=1).
- LFSR_SEED, 16'hACE1, 16-bit LFSR reset value (must be nonzero).

Ports:
- sys_clk  in  1  system clock.
- rst_sw  in  1  synchronous active-low reset.
- rd_bt  in  1  raw random-mode toggle button.
- gen_bt  in  1  raw generate-board button.
- game_s  in  MODE_W  game select; sets the deterministic offset.
- num  in  NUM_W  requested set-cell count.
- rd_led  out  1  current random-mode state.
- gs_led  out  MODE_W  mirror of game_s.
- num_led  out  NUM_W  mirror of num.
- busy  out  1  high while generating.
- board_valid  out  1  high when board holds a completed board.
- board  out  BOARD_W  generated board, bit i = cell i.

Behaviour:
- Reset: sampled on the sys_clk rising edge while rst_sw=0.
  - Reset values: board=0, board_valid=0, busy=0, rd_led=0, FSM=IDLE, LFSR=LFSR_SEED.
  - Debounce counters and flags clear to 0.
  - A reset mid-generation aborts; the partial board is discarded (board=0).
- gs_led and num_led are combinational mirrors of their inputs.
- Debounce, per button:
  - The counter increments while the raw input is 1, saturating at DEB_CYCLES. Any 0 clears it to 0.
  - The flag pulses for exactly 1 cycle on the cycle the counter reaches DEB_CYCLES.
  - Holding the button gives one pulse. A new pulse requires release then a fresh stable press.
- rd_flag toggles rd_led in any state. The new mode applies only to the next generation.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle out of reset, regardless of state.
- FSM states: IDLE, LOAD, FILL, DONE.
- IDLE:
  - gen_flag moves to LOAD.
  - Otherwise hold board and board_valid.
- LOAD (1 cycle):
  - Clear board to 0 and board_valid to 0; set busy=1.
  - Latch the following values:
    - target = min(num, BOARD_W).
    - mode = rd_led.
    - ptr = (game_s * (BOARD_W/4)) mod BOARD_W for deterministic mode, 0 for random mode.
    - placed = 0.
  - If target=0, go to DONE; else go to FILL.
- FILL (one pointer step per cycle):
  - Deterministic mode: set board[ptr] and placed++ every cycle.
  - Random mode: set board[ptr] and placed++ only if board[ptr]==0 and LFSR[0]==1; otherwise no placement.
  - ptr increments each cycle, wrapping BOARD_W-1 -> 0.
  - When placed reaches target (on that cycle's update), go to DONE.
  - Random mode always terminates, since the LFSR is maximal length and an empty cell remains while placed<target.
- DONE (1 cycle): busy=0, board_valid=1, go to IDLE.
- Deterministic latency: gen_flag high at cycle 0, LOAD at cycle 1, FILL at cycles 2..target+1, board_valid=1 and busy=0 from cycle target+2.
- For target=0: board_valid=1 at cycle 2.
- Simultaneous events:
  - gen_flag while busy is ignored and not queued.
  - num and game_s changes during a generation are ignored (latched values are used).
  - rd_flag and gen_flag in the same IDLE cycle: generation uses the old mode; rd_led toggles.
- Width rule: num values >= BOARD_W are clamped, so the board is all ones. Deterministic placements wrap modulo BOARD_W.

Test Plan:
- Reset: hold rst_sw=0 for 3 cycles with buttons pressed -> board=0, board_valid=0, busy=0, rd_led=0, no flags.
- Debounce: gen_bt pulses high for DEB_CYCLES-1 cycles -> no generation. Held high for 40 cycles (DEB_CYCLES=16) -> exactly one generation.
- Deterministic generation: BOARD_W=12, rd_led=0, game_s=2, num=5:
  - ptr starts at 6.
  - board=12'h7C0 (bits 6-10) and board_valid rises 7 cycles after gen_flag.
- Deterministic wrap and clamp:
  - game_s=3, num=4 -> ptr starts at 9, board=12'hE01 (bits 9,10,11,0).
  - num=20 -> board=12'hFFF.
- Random generation: rd_bt press toggles rd_led=1; then gen with num=7:
  - popcount(board)=7 and board_valid=1.
  - The board matches the reference-model LFSR trace.
  - A second generation produces a different board.
- Edge cases:
  - num=0 -> board=0, board_valid at cycle 2.
  - gen_bt pressed during FILL -> ignored.
  - rst_sw=0 during FILL -> board=0, busy=0 on the next cycle.
